ni_inject: RTL

//  Network-interface injection stage for the router's local port (port 5).

---
 rtl/noc_pkg.sv | 52 +++++
 rtl/ni_credit_ctr.sv | 45 ++++
 rtl/ni_inject.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, type codes and the injection FSM state encoding.
// RouteCompute decodes the same field positions.
package noc_pkg;

    localparam int unsigned FLIT_W  = 20;
    localparam int unsigned DATA_W  = 18;
    localparam int unsigned COORD_W = 4;
    localparam int unsigned LEN_W   = 3;

    localparam int unsigned TYPE_HI = 19;
    localparam int unsigned TYPE_LO = 18;
    localparam int unsigned DEST_HI = 17;
    localparam int unsigned DEST_LO = 14;
    localparam int unsigned SRC_HI  = 13;
    localparam int unsigned SRC_LO  = 10;
    localparam int unsigned LEN_HI  = 9;
    localparam int unsigned LEN_LO  = 7;

    typedef enum logic [1:0] {
        FLIT_NONE = 2'b00,
        FLIT_HEAD = 2'b01,
        FLIT_BODY = 2'b10,
        FLIT_TAIL = 2'b11
    } flit_type_e;

    typedef struct packed {
        flit_type_e          ftype;
        logic [DATA_W-1:0]   data;
    } data_flit_t;

    typedef enum logic [1:0] {
        NI_IDLE = 2'd0,
        NI_HEAD = 2'd1,
        NI_DATA = 2'd2
    } ni_state_e;

    // Head flit: type, dest, src, len; low bits reserved as zero.
    function automatic logic [FLIT_W-1:0] make_head(
        input logic [COORD_W-1:0] dest,
        input logic [COORD_W-1:0] src,
        input logic [LEN_W-1:0]   len
    );
        logic [FLIT_W-1:0] f;
        f                  = '0;
        f[TYPE_HI:TYPE_LO] = FLIT_HEAD;
        f[DEST_HI:DEST_LO] = dest;
        f[SRC_HI:SRC_LO]   = src;
        f[LEN_HI:LEN_LO]   = len;
        return f;
    endfunction

endpackage

// File: rtl/ni_credit_ctr.sv
// Credit counter for the router's port-5 input buffer: starts full, saturates at CREDITS.
module ni_credit_ctr #(
    parameter int unsigned CREDITS = 4,
    parameter int unsigned CNT_W   = 3
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             consume,
    input  logic             credit_in,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next,
    output logic             can_send,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(CREDITS);

    // A send and a returned credit in the same cycle cancel out.
    always_comb begin
        count_next = count;
        overflow   = 1'b0;
        unique case ({consume, credit_in})
            2'b10: count_next = count - CNT_W'(1);
            2'b01: begin
                if (count == MAX_CNT) begin
                    overflow = 1'b1;
                end else begin
                    count_next = count + CNT_W'(1);
                end
            end
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            count <= MAX_CNT;
        end else begin
            count <= count_next;
        end
    end

    assign can_send = (count != '0);

endmodule

// File: rtl/ni_inject.sv
// Local-port injection stage: packetizes core descriptors and data words into flits
// and drives them into router port 5 under credit-based flow control.
module ni_inject
    import noc_pkg::*;
#(
    parameter int unsigned CREDITS = 4,
    parameter int unsigned CNT_W   = 3
) (
    input  logic                clk,
    input  logic                RST,
    input  logic [COORD_W-1:0]  position,
    input  logic                msg_valid,
    output logic                msg_ready,
    input  logic [COORD_W-1:0]  msg_dest,
    input  logic [LEN_W-1:0]    msg_len,
    input  logic                data_valid,
    output logic                data_ready,
    input  logic [DATA_W-1:0]   data,
    output logic [FLIT_W-1:0]   flit_out,
    output logic                flit_valid,
    input  logic                credit_in,
    output logic [CNT_W-1:0]    credits,
    output logic                busy,
    output logic                err
);

    ni_state_e            state;
    ni_state_e            state_n;

    logic [COORD_W-1:0]   dest_q;
    logic [COORD_W-1:0]   dest_n;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     len_n;
    logic [LEN_W-1:0]     remaining_q;
    logic [LEN_W-1:0]     remaining_n;

    logic                 msg_fire_c;
    logic                 data_fire_c;
    logic                 len_zero_c;
    logic                 send_c;
    logic [FLIT_W-1:0]    flit_n;
    logic                 err_n;

    logic                 can_send;
    logic                 overflow;
    logic [CNT_W-1:0]     count_next;

    data_flit_t           dflit_c;

    // msg_ready/data_ready are registered images of the IDLE / DATA-with-credit conditions.
    assign msg_fire_c  = msg_valid & msg_ready;
    assign data_fire_c = data_valid & data_ready;
    assign len_zero_c  = (msg_len == LEN_W'(0));
    assign err_n       = err | overflow | (msg_fire_c & len_zero_c);

    ni_credit_ctr #(
        .CREDITS (CREDITS),
        .CNT_W   (CNT_W)
    ) u_credit_ctr (
        .clk        (clk),
        .RST        (RST),
        .consume    (send_c),
        .credit_in  (credit_in),
        .count      (credits),
        .count_next (count_next),
        .can_send   (can_send),
        .overflow   (overflow)
    );

    always_ff @(posedge clk) begin
        if (RST) begin
            state <= NI_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            NI_IDLE: if (msg_fire_c && !len_zero_c) state_n = NI_HEAD;
            NI_HEAD: if (can_send) state_n = NI_DATA;
            NI_DATA: if (data_fire_c && (remaining_q == LEN_W'(1))) state_n = NI_IDLE;
            default: state_n = NI_IDLE;
        endcase
    end

    // Flit build and descriptor bookkeeping; send_c feeds the credit counter.
    always_comb begin
        send_c        = 1'b0;
        flit_n        = '0;
        dest_n        = dest_q;
        len_n         = len_q;
        remaining_n   = remaining_q;
        dflit_c.ftype = FLIT_BODY;
        dflit_c.data  = data;
        unique case (state)
            NI_IDLE: begin
                if (msg_fire_c) begin
                    dest_n      = msg_dest;
                    len_n       = msg_len;
                    remaining_n = msg_len;
                end
            end
            NI_HEAD: begin
                if (can_send) begin
                    send_c = 1'b1;
                    flit_n = make_head(dest_q, position, len_q);
                end
            end
            NI_DATA: begin
                if (data_fire_c) begin
                    send_c        = 1'b1;
                    remaining_n   = remaining_q - LEN_W'(1);
                    dflit_c.ftype = (remaining_q == LEN_W'(1)) ? FLIT_TAIL : FLIT_BODY;
                    flit_n        = dflit_c;
                end
            end
            default: send_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            flit_out    <= '0;
            flit_valid  <= 1'b0;
            msg_ready   <= 1'b1;
            data_ready  <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            dest_q      <= '0;
            len_q       <= '0;
            remaining_q <= '0;
        end else begin
            flit_out    <= flit_n;
            flit_valid  <= send_c;
            msg_ready   <= (state_n == NI_IDLE);
            data_ready  <= (state_n == NI_DATA) && (count_next != '0);
            busy        <= (state_n != NI_IDLE);
            err         <= err_n;
            dest_q      <= dest_n;
            len_q       <= len_n;
            remaining_q <= remaining_n;
        end
    end

endmodule
